pipe_stage_reg: RTL and testbench

//  Parametrised pipeline boundary register for every SammingCPU stage (IF/ID .. MEM/WB).
//  - Latches an opaque payload and a valid bit on clk.
//  - Applies rst > flush > bubble > advance > hold priority, driven by the global stall vector.
//  - Carries a multi-cycle scratch word (hilo_tmp/cnt style) back to the stage while it stalls.
//  - Reports stall-age so CP0/debug can detect hung multi-cycle ops.

---
 rtl/pipe_stage_reg_pkg.sv | 49 ++++
 rtl/pipe_stage_reg_if.sv | 41 ++++
 rtl/pipe_stage_reg_perf_cnt.sv | 30 +++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_pkg
//  Description : Shared types, default sizes and the per-edge action decoder
//                for the pipeline boundary register.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    // Default geometry of a SammingCPU stage boundary
    localparam int c_DATA_W_DEFAULT    = 190;
    localparam int c_SCRATCH_W_DEFAULT = 66;
    localparam int c_STALL_W_DEFAULT   = 6;
    localparam int c_STAGE_IDX_DEFAULT = 3;
    localparam int c_AGE_W_DEFAULT     = 8;
    localparam int c_PERF_W            = 32;

    // What the register does on a given rising edge
    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_ADVANCE = 3'd3,
        ACT_HOLD    = 3'd4
    } stage_act_e;

    // Resolve rst > flush > bubble > advance > hold
    function automatic stage_act_e f_decode_act(
        input logic i_rst,
        input logic i_flush,
        input logic i_s_self,
        input logic i_s_next
    );
        stage_act_e v_act;
        if (i_rst)
            v_act = ACT_RESET;
        else if (i_flush)
            v_act = ACT_FLUSH;
        else if (!i_s_self)
            v_act = ACT_ADVANCE;
        else if (!i_s_next)
            v_act = ACT_BUBBLE;
        else
            v_act = ACT_HOLD;
        return v_act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Stall/flush control plus payload/scratch bus crossing one
//                pipeline stage boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W_DEFAULT,
    parameter int SCRATCH_W = c_SCRATCH_W_DEFAULT,
    parameter int STALL_W   = c_STALL_W_DEFAULT,
    parameter int AGE_W     = c_AGE_W_DEFAULT
);

    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic [SCRATCH_W-1:0] in_scratch;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic [SCRATCH_W-1:0] out_scratch;
    logic [AGE_W-1:0]     stall_age;
    logic                 bubble_o;

    // Producer / control side
    modport master (
        output stall, flush, in_valid, in_data, in_scratch,
        input  out_valid, out_data, out_scratch, stall_age, bubble_o
    );

    // Boundary register side
    modport slave (
        input  stall, flush, in_valid, in_data, in_scratch,
        output out_valid, out_data, out_scratch, stall_age, bubble_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_perf_cnt
//  Description : Free-running event counter, wraps modulo 2^WIDTH, cleared
//                only by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count one per qualified event; natural wrap at the top
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline boundary register. Latches payload and
//                valid, inserts bubbles, carries multi-cycle scratch state
//                back to a stalled producer and tracks stall age.
//                Optional macro PIPE_STAGE_PERF_EN adds bubble/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                  DATA_W      = c_DATA_W_DEFAULT,
    parameter int                  SCRATCH_W   = c_SCRATCH_W_DEFAULT,
    parameter int                  STALL_W     = c_STALL_W_DEFAULT,
    parameter int                  STAGE_IDX   = c_STAGE_IDX_DEFAULT,
    parameter logic [DATA_W-1:0]   NOP_PAYLOAD = '0,
    parameter int                  AGE_W       = c_AGE_W_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_stage_reg_if.slave  bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [c_PERF_W-1:0] perf_bubbles,
    output logic [c_PERF_W-1:0] perf_flushes
`endif
);

    // The consumer's stall bit must exist in the vector
    generate
        if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
        end
    endgenerate

    logic                 w_s_self;
    logic                 w_s_next;
    stage_act_e           w_act;
    logic [AGE_W-1:0]     w_age_inc;
    logic                 w_unused_stall;

    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [SCRATCH_W-1:0] r_scratch;
    logic [AGE_W-1:0]     r_age;
    logic                 r_bubble;

    assign w_s_self       = bus.stall[STAGE_IDX];
    assign w_s_next       = bus.stall[STAGE_IDX+1];
    assign w_unused_stall = ^bus.stall;

    // Decode this edge's action from the priority chain
    assign w_act = f_decode_act(rst, bus.flush, w_s_self, w_s_next);

    // Saturating increment: once all ones, age stays put
    assign w_age_inc = (r_age == {AGE_W{1'b1}}) ? r_age : r_age + AGE_W'(1);

    // Boundary state update; stalled edges keep payload and feed scratch back
    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH: begin
                r_valid   <= 1'b0;
                r_data    <= NOP_PAYLOAD;
                r_scratch <= '0;
                r_age     <= '0;
                r_bubble  <= 1'b0;
            end
            ACT_BUBBLE: begin
                r_valid   <= 1'b0;
                r_data    <= NOP_PAYLOAD;
                r_scratch <= bus.in_scratch;
                r_age     <= w_age_inc;
                r_bubble  <= 1'b1;
            end
            ACT_ADVANCE: begin
                r_valid   <= bus.in_valid;
                r_data    <= bus.in_data;
                r_scratch <= '0;
                r_age     <= '0;
                r_bubble  <= 1'b0;
            end
            default: begin
                r_scratch <= bus.in_scratch;
                r_age     <= w_age_inc;
                r_bubble  <= 1'b0;
            end
        endcase
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_data    = r_data;
    assign bus.out_scratch = r_scratch;
    assign bus.stall_age   = r_age;
    assign bus.bubble_o    = r_bubble;

`ifdef PIPE_STAGE_PERF_EN
    logic w_bubble_evt;
    logic w_flush_evt;

    // A flush only counts when it actually discards an instruction
    assign w_bubble_evt = (w_act == ACT_BUBBLE);
    assign w_flush_evt  = (w_act == ACT_FLUSH) && (r_valid || bus.in_valid);

    pipe_perf_cnt #(
        .WIDTH (c_PERF_W)
    ) u_perf_bubbles (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_bubble_evt),
        .o_count (perf_bubbles)
    );

    pipe_perf_cnt #(
        .WIDTH (c_PERF_W)
    ) u_perf_flushes (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush_evt),
        .o_count (perf_flushes)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg: directed scenarios
//                followed by random stimulus against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W    = 190;
    localparam int SCRATCH_W = 66;
    localparam int STALL_W   = 6;
    localparam int STAGE_IDX = 3;
    localparam int AGE_W     = 8;
    localparam int AGE_MAX   = (1 << AGE_W) - 1;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic                 m_valid;
    logic [DATA_W-1:0]    m_data;
    logic [SCRATCH_W-1:0] m_scratch;
    int                   m_age;
    logic                 m_bubble;
    int                   m_bubbles;
    int                   m_flushes;

    logic [DATA_W-1:0]    held_data;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(
        .DATA_W    (DATA_W),
        .SCRATCH_W (SCRATCH_W),
        .STALL_W   (STALL_W),
        .AGE_W     (AGE_W)
    ) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .SCRATCH_W   (SCRATCH_W),
        .STALL_W     (STALL_W),
        .STAGE_IDX   (STAGE_IDX),
        .NOP_PAYLOAD ('0),
        .AGE_W       (AGE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [223:0] t;
        t = '0;
        for (int i = 0; i < 7; i++) t = {t[191:0], $urandom()};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [SCRATCH_W-1:0] rnd_scratch();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[SCRATCH_W-1:0];
    endfunction

    // Apply the stage rules to the model using the inputs seen at this edge
    task automatic model_edge();
        logic s_self;
        logic s_next;
        s_self = bus.stall[STAGE_IDX];
        s_next = bus.stall[STAGE_IDX+1];
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_scratch = '0;
            m_age = 0; m_bubble = 1'b0; m_bubbles = 0; m_flushes = 0;
        end else if (bus.flush) begin
            if (m_valid || bus.in_valid) m_flushes++;
            m_valid = 1'b0; m_data = '0; m_scratch = '0;
            m_age = 0; m_bubble = 1'b0;
        end else if (!s_self) begin
            m_valid = bus.in_valid; m_data = bus.in_data;
            m_scratch = '0; m_age = 0; m_bubble = 1'b0;
        end else begin
            m_scratch = bus.in_scratch;
            m_age     = (m_age < AGE_MAX) ? m_age + 1 : AGE_MAX;
            m_bubble  = !s_next;
            if (!s_next) begin
                m_valid = 1'b0; m_data = '0; m_bubbles++;
            end
        end
    endtask

    task automatic compare_model();
        chk("out_valid",   bus.out_valid,   m_valid);
        chk("out_data",    bus.out_data,    m_data);
        chk("out_scratch", bus.out_scratch, m_scratch);
        chk("stall_age",   bus.stall_age,   m_age);
        chk("bubble_o",    bus.bubble_o,    m_bubble);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_bubbles", perf_bubbles, m_bubbles);
        chk("perf_flushes", perf_flushes, m_flushes);
`endif
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    initial begin
        // Reset with all-ones payload present
        rst = 1'b1;
        bus.stall = '0; bus.flush = 1'b0; bus.in_valid = 1'b1;
        bus.in_data = '1; bus.in_scratch = '1;
        tick(); tick();
        chk("rst_valid",   bus.out_valid,   1'b0);
        chk("rst_data",    bus.out_data,    '0);
        chk("rst_scratch", bus.out_scratch, '0);
        chk("rst_age",     bus.stall_age,   '0);

        // Plain advance
        rst = 1'b0;
        bus.stall = 6'b000000; bus.in_valid = 1'b1;
        bus.in_data = DATA_W'(8'hA5); bus.in_scratch = rnd_scratch();
        tick();
        chk("adv_valid",   bus.out_valid,   1'b1);
        chk("adv_data",    bus.out_data,    DATA_W'(8'hA5));
        chk("adv_scratch", bus.out_scratch, '0);

        // Bubble: producer stopped, consumer free
        bus.stall = 6'b001111;
        bus.in_scratch = 66'h2_0000_0001_0000_0002;
        tick();
        chk("bub_valid",   bus.out_valid,   1'b0);
        chk("bub_pulse",   bus.bubble_o,    1'b1);
        chk("bub_scratch", bus.out_scratch, 66'h2_0000_0001_0000_0002);
        chk("bub_age",     bus.stall_age,   8'd1);

        // Advance a known payload, then hold it through a long stall
        bus.stall = 6'b000000; held_data = rnd_data(); bus.in_data = held_data;
        tick();
        bus.stall = 6'b011111;
        for (int i = 0; i < 300; i++) begin
            bus.in_data = rnd_data(); bus.in_scratch = rnd_scratch();
            bus.in_valid = 1'($urandom());
            tick();
        end
        chk("hold_data",  bus.out_data,  held_data);
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_age",   bus.stall_age, 8'd255);
        chk("hold_pulse", bus.bubble_o,  1'b0);

        // Flush beats a bubble-producing stall
        bus.flush = 1'b1; bus.stall = 6'b001111; bus.in_scratch = rnd_scratch();
        tick();
        chk("fl_valid",   bus.out_valid,   1'b0);
        chk("fl_scratch", bus.out_scratch, '0);
        chk("fl_age",     bus.stall_age,   '0);
        chk("fl_pulse",   bus.bubble_o,    1'b0);
        bus.flush = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Three bubbles and two flushes from a clean reset
        rst = 1'b1; tick(); rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.stall = 6'b001111;
        tick(); tick(); tick();
        bus.stall = 6'b000000; bus.flush = 1'b1;
        tick(); tick();
        bus.flush = 1'b0;
        chk("perf_bub3", perf_bubbles, 32'd3);
        chk("perf_fl2",  perf_flushes, 32'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("perf_bub_rst", perf_bubbles, 32'd0);
        chk("perf_fl_rst",  perf_flushes, 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.stall    = STALL_W'($urandom_range(0, 63));
            bus.in_valid = 1'($urandom());
            bus.in_data  = rnd_data();
            bus.in_scratch = rnd_scratch();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
